// File: rtl/fft_pkg.sv
// Shared constants, sample/bank-state types and the bit-reversal helper for the
// FFT input staging logic.
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;
  localparam int FFT_DW    = 16;

  typedef logic signed [FFT_DW-1:0] sample_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    BUSY
  } bank_state_e;

  // Reverses the low 'width' bits of idx (width <= FFT_LOG2N).
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx,
                                                   input int width);
    logic [FFT_LOG2N-1:0] full_rev;
    full_rev = {<<{idx}};
    return full_rev >> (FFT_LOG2N - width);
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of complex samples held in registers: single write port, whole-bank
// synchronous clear (clear wins over write) and full parallel read-out.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int DW    = FFT_DW
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_we,
  input  logic [LOG2N-1:0] i_addr,
  input  logic [DW-1:0]    i_re,
  input  logic [DW-1:0]    i_im,
  output logic [DW-1:0]    o_re [N],
  output logic [DW-1:0]    o_im [N]
);

  logic [DW-1:0] r_re [N];
  logic [DW-1:0] r_im [N];

  always_ff @(posedge clk) begin
    if (i_clear) begin
      for (int i = 0; i < N; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else if (i_we) begin
      r_re[i_addr] <= i_re;
      r_im[i_addr] <= i_im;
    end
  end

  assign o_re = r_re;
  assign o_im = r_im;

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong input buffer for the 64-point FFT: serial samples are stored at
// bit-reversed addresses and completed frames are presented in parallel.
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int DW    = FFT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] output_Re [N],
  output logic [DW-1:0] output_Im [N],
  output logic          start,
  input  logic          fft_done,
  output logic          frame_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  bank_state_e      r_bank_state [2];
  logic [LOG2N-1:0] r_wr_idx;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [0:0]       r_state;
  logic             r_start;
  logic             r_frame_err;
  logic             r_in_ready;
  logic [DW-1:0]    r_out_re [N];
  logic [DW-1:0]    r_out_im [N];

  bank_state_e      w_bank_state_next [2];
  logic             w_xfer;
  logic             w_is_end;
  logic             w_err;
  logic             w_complete;
  logic [LOG2N-1:0] w_wr_addr;
  logic             w_run_done;
  logic             w_next_rd;
  logic             w_fsm_free;
  logic             w_present;
  logic             w_fwd;
  logic             w_wr_bank_next;
  logic             w_we0;
  logic             w_we1;
  logic             w_clr0;
  logic             w_clr1;
  logic [DW-1:0]    w_bank0_re [N];
  logic [DW-1:0]    w_bank0_im [N];
  logic [DW-1:0]    w_bank1_re [N];
  logic [DW-1:0]    w_bank1_im [N];
  logic [DW-1:0]    w_sel_re [N];
  logic [DW-1:0]    w_sel_im [N];

  assign w_xfer         = in_valid && r_in_ready;
  assign w_is_end       = &r_wr_idx;
  assign w_err          = w_xfer && (in_last != w_is_end);
  assign w_complete     = w_xfer && in_last && w_is_end;
  assign w_wr_addr      = bitrev(r_wr_idx, LOG2N);
  assign w_wr_bank_next = r_wr_bank ^ w_complete;

  // fft_done frees the FSM in the same cycle, so a bank that is already FULL
  // (or completing right now) is presented on the very next edge.
  assign w_run_done = (r_state == S_RUN) && fft_done;
  assign w_next_rd  = w_run_done ? ~r_rd_bank : r_rd_bank;
  assign w_fsm_free = (r_state == S_IDLE) || w_run_done;
  assign w_fwd      = w_complete && (r_wr_bank == w_next_rd);
  assign w_present  = w_fsm_free && ((r_bank_state[w_next_rd] == FULL) || w_fwd);

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_state_next[b] = r_bank_state[b];
      if (w_run_done && (r_rd_bank == 1'(b))) begin
        w_bank_state_next[b] = EMPTY;
      end
      if (w_xfer && (r_wr_bank == 1'(b))) begin
        if (w_err) begin
          w_bank_state_next[b] = EMPTY;
        end else if (w_complete) begin
          w_bank_state_next[b] = FULL;
        end else begin
          w_bank_state_next[b] = FILLING;
        end
      end
      if (w_present && (w_next_rd == 1'(b))) begin
        w_bank_state_next[b] = BUSY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_state[0] <= EMPTY;
      r_bank_state[1] <= EMPTY;
      r_wr_idx        <= '0;
      r_wr_bank       <= 1'b0;
      r_rd_bank       <= 1'b0;
      r_state         <= S_IDLE;
      r_start         <= 1'b0;
      r_frame_err     <= 1'b0;
      r_in_ready      <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_bank_state[b] <= w_bank_state_next[b];
      end
      if (w_xfer) begin
        r_wr_idx <= (w_err || w_complete) ? '0 : r_wr_idx + 1'b1;
      end
      r_wr_bank <= w_wr_bank_next;
      r_rd_bank <= w_next_rd;
      if (w_present) begin
        r_state <= S_RUN;
      end else if (w_run_done) begin
        r_state <= S_IDLE;
      end
      r_start <= w_present;
      if (w_err) begin
        r_frame_err <= 1'b1;
      end
      r_in_ready <= (w_bank_state_next[w_wr_bank_next] == EMPTY) ||
                    (w_bank_state_next[w_wr_bank_next] == FILLING);
    end
  end

  // The final sample lands in the bank on the presenting edge, so forward it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_out_re[i] <= '0;
        r_out_im[i] <= '0;
      end
    end else if (w_present) begin
      for (int i = 0; i < N; i++) begin
        r_out_re[i] <= w_sel_re[i];
        r_out_im[i] <= w_sel_im[i];
      end
      if (w_fwd) begin
        r_out_re[w_wr_addr] <= in_re;
        r_out_im[w_wr_addr] <= in_im;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_sel
      assign w_sel_re[gi] = w_next_rd ? w_bank1_re[gi] : w_bank0_re[gi];
      assign w_sel_im[gi] = w_next_rd ? w_bank1_im[gi] : w_bank0_im[gi];
    end
  endgenerate

  assign w_we0  = w_xfer && !w_err && (r_wr_bank == 1'b0);
  assign w_we1  = w_xfer && !w_err && (r_wr_bank == 1'b1);
  assign w_clr0 = rst || (w_err && (r_wr_bank == 1'b0));
  assign w_clr1 = rst || (w_err && (r_wr_bank == 1'b1));

  fft_frame_bank #(
    .N     (N),
    .LOG2N (LOG2N),
    .DW    (DW)
  ) u_bank0 (
    .clk     (clk),
    .i_clear (w_clr0),
    .i_we    (w_we0),
    .i_addr  (w_wr_addr),
    .i_re    (in_re),
    .i_im    (in_im),
    .o_re    (w_bank0_re),
    .o_im    (w_bank0_im)
  );

  fft_frame_bank #(
    .N     (N),
    .LOG2N (LOG2N),
    .DW    (DW)
  ) u_bank1 (
    .clk     (clk),
    .i_clear (w_clr1),
    .i_we    (w_we1),
    .i_addr  (w_wr_addr),
    .i_re    (in_re),
    .i_im    (in_im),
    .o_re    (w_bank1_re),
    .o_im    (w_bank1_im)
  );

  assign in_ready  = r_in_ready;
  assign start     = r_start;
  assign frame_err = r_frame_err;
  assign output_Re = r_out_re;
  assign output_Im = r_out_im;

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed + randomized bench for fft_input_buffer; the reference keeps whole
// frames placed by bit-reversed sample number and a queue of frames to present.
module tb_fft_input_buffer;
  import fft_pkg::*;

  localparam int NP = FFT_N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] output_Re [NP];
  logic [15:0] output_Im [NP];
  logic        start;
  logic        fft_done = 1'b0;
  logic        frame_err;

  always #5 clk = ~clk;

  fft_input_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .output_Re (output_Re),
    .output_Im (output_Im),
    .start     (start),
    .fft_done  (fft_done),
    .frame_err (frame_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_starts = 0;
  int last_start_cyc = -1;
  int last_xfer_cyc = -1;
  int base;
  logic [15:0] sent_re [NP];
  logic [15:0] sent_im [NP];
  logic [NP*16-1:0] q_re [$];
  logic [NP*16-1:0] q_im [$];

  function automatic int brev(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 6; k++) begin
      if (((n >> k) & 1) != 0) r += (32 >> k);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (start === 1'b1) begin
      n_starts++;
      last_start_cyc = cyc;
    end
  endtask

  task automatic send_frame(input int cnt, input int last_at, input int gap_pct, input bit ramp);
    int n;
    int stall;
    bit go;
    bit xfer;
    logic [NP*16-1:0] fr;
    logic [NP*16-1:0] fi;
    n = 0;
    stall = 0;
    fr = '0;
    fi = '0;
    while (n < cnt && stall < 1000) begin
      go = ($urandom_range(0, 99) >= gap_pct);
      in_valid = go;
      in_re = ramp ? 16'(n) : 16'($urandom);
      in_im = ramp ? 16'(-n) : 16'($urandom);
      in_last = (n == last_at);
      xfer = go && (in_ready === 1'b1);
      if (xfer) begin
        sent_re[n] = in_re;
        sent_im[n] = in_im;
        fr[16*brev(n) +: 16] = in_re;
        fi[16*brev(n) +: 16] = in_im;
      end
      step();
      if (xfer) begin
        last_xfer_cyc = cyc;
        n++;
      end else begin
        stall++;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("send_complete", n, cnt);
    if (n == cnt && cnt == NP && last_at == NP - 1) begin
      q_re.push_back(fr);
      q_im.push_back(fi);
    end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_queued"}, 32'(q_re.size() != 0), 32'd1);
    if (q_re.size() != 0) begin
      for (int i = 0; i < NP; i++) begin
        chk($sformatf("%s_re%0d", tag, i), output_Re[i], q_re[0][16*i +: 16]);
        chk($sformatf("%s_im%0d", tag, i), output_Im[i], q_im[0][16*i +: 16]);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s_re%0d", tag, i), output_Re[i], 32'd0);
      chk($sformatf("%s_im%0d", tag, i), output_Im[i], 32'd0);
    end
  endtask

  task automatic release_frame();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    if (q_re.size() != 0) begin
      void'(q_re.pop_front());
      void'(q_im.pop_front());
    end
  endtask

  initial begin
    // Reset held for two cycles
    rst = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_frame_err", frame_err, 0);
    check_zero("rst_out");
    step();
    chk("rst2_in_ready", in_ready, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    $display("txn reset: in_ready=%0b start=%0b frame_err=%0b", in_ready, start, frame_err);

    // Ramp frame, continuous valid
    base = n_starts;
    send_frame(NP, NP - 1, 0, 1'b1);
    chk("ramp_start_cyc", last_start_cyc, last_xfer_cyc);
    chk("ramp_re1", output_Re[1], 32'd32);
    chk("ramp_re3", output_Re[3], 32'd48);
    chk("ramp_re63", output_Re[63], 32'd63);
    chk("ramp_im1", output_Im[1], 32'(16'hFFE0));
    check_frame("ramp");
    step();
    chk("ramp_start_one_cycle", start, 0);
    chk("ramp_start_count", n_starts - base, 1);
    release_frame();
    chk("ramp_after_done_start", start, 0);
    $display("txn ramp frame: starts=%0d bad=%0d", n_starts - base, bad);

    // Two back-to-back frames, only the first is presented until fft_done
    base = n_starts;
    send_frame(NP, NP - 1, 0, 1'b0);
    chk("b2b_a_start_cyc", last_start_cyc, last_xfer_cyc);
    check_frame("b2b_a");
    send_frame(NP, NP - 1, 0, 1'b0);
    chk("b2b_in_ready_drop", in_ready, 0);
    chk("b2b_one_start", n_starts - base, 1);
    check_frame("b2b_a_hold");
    step();
    chk("b2b_in_ready_low", in_ready, 0);
    release_frame();
    chk("b2b_b_start", start, 1);
    chk("b2b_in_ready_back", in_ready, 1);
    chk("b2b_b_re1", output_Re[1], sent_re[32]);
    check_frame("b2b_b");
    step();
    chk("b2b_b_start_pulse", start, 0);
    release_frame();
    $display("txn back-to-back: starts=%0d bad=%0d", n_starts - base, bad);

    // Early in_last, then missing in_last, each followed by a clean frame
    base = n_starts;
    send_frame(11, 10, 0, 1'b0);
    chk("err_early_flag", frame_err, 1);
    step();
    chk("err_early_no_start", n_starts - base, 0);
    send_frame(NP, NP - 1, 0, 1'b0);
    chk("err_recover_start_cyc", last_start_cyc, last_xfer_cyc);
    check_frame("err_recover");
    release_frame();
    base = n_starts;
    send_frame(NP, -1, 0, 1'b0);
    step();
    chk("err_nolast_no_start", n_starts - base, 0);
    chk("err_sticky", frame_err, 1);
    send_frame(NP, NP - 1, 0, 1'b0);
    chk("err_recover2_start_cyc", last_start_cyc, last_xfer_cyc);
    check_frame("err_recover2");
    release_frame();
    $display("txn framing errors: frame_err=%0b bad=%0d", frame_err, bad);

    // Reset after a partial frame
    base = n_starts;
    send_frame(30, -1, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q_re.delete();
    q_im.delete();
    step();
    chk("prst_no_start", n_starts - base, 0);
    chk("prst_frame_err_clr", frame_err, 0);
    chk("prst_in_ready", in_ready, 1);
    check_zero("prst_out");
    send_frame(NP, NP - 1, 0, 1'b0);
    chk("prst_start_cyc", last_start_cyc, last_xfer_cyc);
    chk("prst_one_start", n_starts - base, 1);
    check_frame("prst");
    release_frame();
    $display("txn partial-reset: starts=%0d bad=%0d", n_starts - base, bad);

    // fft_done while idle is ignored, then a gappy ramp frame
    base = n_starts;
    release_frame();
    step();
    chk("idle_done_no_start", n_starts - base, 0);
    chk("idle_done_in_ready", in_ready, 1);
    send_frame(NP, NP - 1, 50, 1'b1);
    chk("gap_start_cyc", last_start_cyc, last_xfer_cyc);
    chk("gap_re1", output_Re[1], 32'd32);
    chk("gap_re3", output_Re[3], 32'd48);
    chk("gap_im1", output_Im[1], 32'(16'hFFE0));
    check_frame("gap");
    release_frame();
    $display("txn gappy ramp: starts=%0d bad=%0d", n_starts - base, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
